control_sequencer: RTL and testbench

Multi-cycle control sequencer for the 4-bit processor. It generates the 4-bit control-state code consumed by the one-hot state decoder: 0000 fetch0, 0001 fetch1, then 0010–1111 for the execute state of the fetched instruction. It also drives the memory, register-file and PC strobes for each state. It sits between the instruction/memory path and the datapath, and it owns the compare flags used by the conditional jumps.

---
 rtl/control_sequencer.sv | 135 +++++++++++++
 tb/tb_control_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 4-bit processor: fetch/execute state code,
// memory/register/PC strobes, compare flags and a retired-instruction counter.
module control_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        mem_ready,
    input  logic [3:0]  mem_opcode,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic [3:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        reg_we,
    output logic        flag_z,
    output logic        flag_c,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH0  = 4'h0,
        FETCH1  = 4'h1,
        ADD_AND = 4'h2,
        ADDI    = 4'h3,
        ANDI    = 4'h4,
        NR      = 4'h5,
        NND     = 4'h6,
        JMP     = 4'h7,
        LD      = 4'h8,
        ST      = 4'h9,
        COMP    = 4'hA,
        JE      = 4'hB,
        JA      = 4'hC,
        JB      = 4'hD,
        JAE     = 4'hE,
        JBE     = 4'hF
    } state_t;

    state_t      cur_state;
    logic [3:0]  opcode_q;
    logic        flag_z_q;
    logic        flag_c_q;
    logic [15:0] instr_count_q;
    logic        exec_done;

    // An execute state retires on its last cycle; memory ops wait for mem_ready.
    always_comb begin
        exec_done = 1'b0;
        if (cur_state != FETCH0 && cur_state != FETCH1) begin
            if (cur_state == LD || cur_state == ST)
                exec_done = mem_ready;
            else
                exec_done = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state     <= FETCH0;
            opcode_q      <= '0;
            flag_z_q      <= 1'b0;
            flag_c_q      <= 1'b0;
            instr_count_q <= '0;
        end else if (!hold) begin
            if (exec_done)
                instr_count_q <= instr_count_q + 16'd1;
            case (cur_state)
                FETCH0: begin
                    if (mem_ready) begin
                        opcode_q  <= mem_opcode;
                        cur_state <= FETCH1;
                    end
                end
                FETCH1: cur_state <= (opcode_q >= 4'h2) ? state_t'(opcode_q) : FETCH0;
                LD, ST: begin
                    if (mem_ready)
                        cur_state <= FETCH0;
                end
                COMP: begin
                    flag_z_q  <= alu_zero;
                    flag_c_q  <= alu_carry;
                    cur_state <= FETCH0;
                end
                default: cur_state <= FETCH0;
            endcase
        end
    end

    // Strobes are gated off during reset and hold so no access starts while frozen.
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        reg_we  = 1'b0;
        illegal = 1'b0;
        if (!rst && !hold) begin
            case (cur_state)
                FETCH0: mem_req = 1'b1;
                FETCH1: begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    illegal = (opcode_q < 4'h2);
                end
                ADD_AND, ADDI, ANDI, NR, NND: reg_we = 1'b1;
                JMP: pc_load = 1'b1;
                LD: begin
                    mem_req = 1'b1;
                    reg_we  = mem_ready;
                end
                ST: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                JE:  pc_load = flag_z_q;
                JA:  pc_load = !flag_c_q && !flag_z_q;
                JB:  pc_load = flag_c_q;
                JAE: pc_load = !flag_c_q;
                JBE: pc_load = flag_c_q || flag_z_q;
                default: ;
            endcase
        end
    end

    assign state       = cur_state;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        mem_ready = 1'b0;
    logic [3:0]  mem_opcode = '0;
    logic        alu_zero = 1'b0;
    logic        alu_carry = 1'b0;
    logic [3:0]  state;
    logic        mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we;
    logic        flag_z, flag_c, illegal;
    logic [15:0] instr_count;

    control_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .mem_ready   (mem_ready),
        .mem_opcode  (mem_opcode),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .state       (state),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .reg_we      (reg_we),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // strobe vector order: {mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we, illegal}
    localparam logic [6:0] NO = 7'b0000000;
    localparam logic [6:0] MR = 7'b1000000;
    localparam logic [6:0] WE = 7'b0100000;
    localparam logic [6:0] IR = 7'b0010000;
    localparam logic [6:0] PI = 7'b0001000;
    localparam logic [6:0] PL = 7'b0000100;
    localparam logic [6:0] RW = 7'b0000010;
    localparam logic [6:0] IL = 7'b0000001;

    typedef struct {
        logic [3:0]  st;
        logic [6:0]  stb;
        logic [1:0]  flg;   // {flag_z, flag_c}
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input logic r, input logic h, input logic mr, input logic [3:0] op,
                        input logic z, input logic c, input logic [3:0] es, input logic [6:0] estb,
                        input logic [1:0] ef, input logic [15:0] ec, input string nm);
        exp_t e;
        rst = r; hold = h; mem_ready = mr; mem_opcode = op; alu_zero = z; alu_carry = c;
        e.st = es; e.stb = estb; e.flg = ef; e.cnt = ec; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] stb;
            e = exp_q.pop_front();
            stb = {mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we, illegal};
            checks += 4;
            if (state !== e.st) begin
                errors++;
                $display("FAIL %s state: got %h expected %h", e.name, state, e.st);
            end
            if (stb !== e.stb) begin
                errors++;
                $display("FAIL %s strobes: got %b expected %b", e.name, stb, e.stb);
            end
            if ({flag_z, flag_c} !== e.flg) begin
                errors++;
                $display("FAIL %s flags(z,c): got %b expected %b", e.name, {flag_z, flag_c}, e.flg);
            end
            if (instr_count !== e.cnt) begin
                errors++;
                $display("FAIL %s instr_count: got %h expected %h", e.name, instr_count, e.cnt);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        //   rst  hold mr  op    z  c   state strobes      flags cnt       name
        step(1, 0, 0, 4'h0, 0, 0, 4'h0, NO,          2'b00, 16'd0, "reset");
        // addI 0011
        step(0, 0, 1, 4'h3, 0, 0, 4'h0, MR,          2'b00, 16'd0, "addi_f0");
        step(0, 0, 1, 4'h0, 0, 0, 4'h1, IR|PI,       2'b00, 16'd0, "addi_f1");
        step(0, 0, 1, 4'h0, 0, 0, 4'h3, RW,          2'b00, 16'd0, "addi_ex");
        // ld with two wait cycles
        step(0, 0, 1, 4'h8, 0, 0, 4'h0, MR,          2'b00, 16'd1, "ld_f0");
        step(0, 0, 0, 4'h0, 0, 0, 4'h1, IR|PI,       2'b00, 16'd1, "ld_f1");
        step(0, 0, 0, 4'h0, 0, 0, 4'h8, MR,          2'b00, 16'd1, "ld_wait1");
        step(0, 0, 0, 4'h0, 0, 0, 4'h8, MR,          2'b00, 16'd1, "ld_wait2");
        step(0, 0, 1, 4'h0, 0, 0, 4'h8, MR|RW,       2'b00, 16'd1, "ld_done");
        // comp z=0 c=1, then jb (taken) and jae (not taken)
        step(0, 0, 1, 4'hA, 0, 0, 4'h0, MR,          2'b00, 16'd2, "comp1_f0");
        step(0, 0, 0, 4'h0, 0, 0, 4'h1, IR|PI,       2'b00, 16'd2, "comp1_f1");
        step(0, 0, 0, 4'h0, 0, 1, 4'hA, NO,          2'b00, 16'd2, "comp1_ex");
        step(0, 0, 1, 4'hD, 1, 0, 4'h0, MR,          2'b01, 16'd3, "jb_f0");
        step(0, 0, 1, 4'h0, 1, 0, 4'h1, IR|PI,       2'b01, 16'd3, "jb_f1");
        step(0, 0, 1, 4'h0, 1, 0, 4'hD, PL,          2'b01, 16'd3, "jb_ex");
        step(0, 0, 1, 4'hE, 0, 0, 4'h0, MR,          2'b01, 16'd4, "jae_f0");
        step(0, 0, 1, 4'h0, 0, 0, 4'h1, IR|PI,       2'b01, 16'd4, "jae_f1");
        step(0, 0, 1, 4'h0, 0, 0, 4'hE, NO,          2'b01, 16'd4, "jae_ex");
        // comp z=1 c=0, then je (taken)
        step(0, 0, 1, 4'hA, 0, 0, 4'h0, MR,          2'b01, 16'd5, "comp2_f0");
        step(0, 0, 1, 4'h0, 0, 0, 4'h1, IR|PI,       2'b01, 16'd5, "comp2_f1");
        step(0, 0, 1, 4'h0, 1, 0, 4'hA, NO,          2'b01, 16'd5, "comp2_ex");
        step(0, 0, 1, 4'hB, 0, 1, 4'h0, MR,          2'b10, 16'd6, "je_f0");
        step(0, 0, 1, 4'h0, 0, 1, 4'h1, IR|PI,       2'b10, 16'd6, "je_f1");
        step(0, 0, 1, 4'h0, 0, 1, 4'hB, PL,          2'b10, 16'd6, "je_ex");
        // illegal opcode 0001
        step(0, 0, 1, 4'h1, 0, 0, 4'h0, MR,          2'b10, 16'd7, "ill_f0");
        step(0, 0, 1, 4'h0, 0, 0, 4'h1, IR|PI|IL,    2'b10, 16'd7, "ill_f1");
        step(0, 0, 0, 4'h0, 0, 0, 4'h0, MR,          2'b10, 16'd7, "ill_back");
        // hold for 4 cycles in FETCH0 with mem_ready high
        for (int i = 0; i < 4; i++)
            step(0, 1, 1, 4'h2, 0, 0, 4'h0, NO,      2'b10, 16'd7, "hold_f0");
        step(0, 0, 1, 4'h2, 0, 0, 4'h0, MR,          2'b10, 16'd7, "hold_rel");
        step(0, 0, 0, 4'h0, 0, 0, 4'h1, IR|PI,       2'b10, 16'd7, "add_f1");
        step(0, 0, 0, 4'h0, 0, 0, 4'h2, RW,          2'b10, 16'd7, "add_ex");
        // preload the counter to 0xFFFF while idling in FETCH0
        force dut.instr_count_q = 16'hFFFF;
        #1;
        release dut.instr_count_q;
        step(0, 0, 1, 4'h2, 0, 0, 4'h0, MR,          2'b10, 16'hFFFF, "wrap_f0");
        step(0, 0, 1, 4'h0, 0, 0, 4'h1, IR|PI,       2'b10, 16'hFFFF, "wrap_f1");
        step(0, 0, 1, 4'h0, 0, 0, 4'h2, RW,          2'b10, 16'hFFFF, "wrap_ex");
        // st, reset during its wait
        step(0, 0, 1, 4'h9, 0, 0, 4'h0, MR,          2'b10, 16'd0, "st_f0");
        step(0, 0, 0, 4'h0, 0, 0, 4'h1, IR|PI,       2'b10, 16'd0, "st_f1");
        step(0, 0, 0, 4'h0, 0, 0, 4'h9, MR|WE,       2'b10, 16'd0, "st_wait");
        step(1, 0, 1, 4'h0, 0, 0, 4'h9, NO,          2'b10, 16'd0, "st_rst");
        step(1, 0, 1, 4'h0, 0, 0, 4'h0, NO,          2'b00, 16'd0, "post_rst");
        step(0, 0, 0, 4'h0, 0, 0, 4'h0, MR,          2'b00, 16'd0, "refetch");
        // jmp after reset
        step(0, 0, 1, 4'h7, 0, 0, 4'h0, MR,          2'b00, 16'd0, "jmp_f0");
        step(0, 0, 1, 4'h0, 0, 0, 4'h1, IR|PI,       2'b00, 16'd0, "jmp_f1");
        step(0, 0, 0, 4'h0, 0, 0, 4'h7, PL,          2'b00, 16'd0, "jmp_ex");
        step(0, 0, 0, 4'h0, 0, 0, 4'h0, MR,          2'b00, 16'd1, "jmp_done");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left, expected 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
